// File: rtl/score_keeper.sv
// Pong game-state controller: samples the ball once per frame, scores goals,
// detects a win and sequences menu / serve / play / game-over for the ball logic.
module score_keeper #(
  parameter int WIN_SCORE    = 5,
  parameter int LEFT_GOAL    = 10,
  parameter int RIGHT_GOAL   = 630,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  output logic [9:0] score1,
  output logic [9:0] score2,
  output logic       menu,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       ball_hold,
  output logic       ball_reset,
  output logic       serve_dir
);

  typedef enum logic [1:0] {
    MENU,
    SERVE,
    PLAY,
    OVER
  } state_t;

  localparam logic [9:0] WIN_LIM   = 10'(WIN_SCORE);
  localparam logic [9:0] LEFT_LIM  = 10'(LEFT_GOAL);
  localparam logic [9:0] RIGHT_LIM = 10'(RIGHT_GOAL);
  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] OVER_CNT  = 8'(OVER_FRAMES);

  state_t     state;
  logic       start_q;
  logic       start_edge;
  logic [7:0] frame_cnt;
  logic [7:0] cnt_inc;
  logic [9:0] score1_inc;
  logic [9:0] score2_inc;

  assign start_edge = start & ~start_q;
  assign cnt_inc    = frame_cnt + 8'd1;
  assign score1_inc = score1 + 10'd1;
  assign score2_inc = score2 + 10'd1;

  // frame_cnt only runs in the timed phases and restarts at every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= MENU;
      start_q    <= 1'b0;
      frame_cnt  <= 8'd0;
      score1     <= 10'd0;
      score2     <= 10'd0;
      winner     <= 2'b00;
      serve_dir  <= 1'b0;
      ball_reset <= 1'b0;
      ball_hold  <= 1'b1;
      menu       <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      start_q    <= start;
      ball_reset <= 1'b0;
      case (state)
        MENU: begin
          if (start_edge) begin
            score1     <= 10'd0;
            score2     <= 10'd0;
            winner     <= 2'b00;
            serve_dir  <= 1'b0;
            ball_reset <= 1'b1;
            ball_hold  <= 1'b1;
            menu       <= 1'b0;
            frame_cnt  <= 8'd0;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt_inc == SERVE_CNT) begin
              frame_cnt <= 8'd0;
              ball_hold <= 1'b0;
              state     <= PLAY;
            end else begin
              frame_cnt <= cnt_inc;
            end
          end
        end
        PLAY: begin
          // Left border is checked first so a degenerate position favours player 2.
          if (frame_tick) begin
            if (ball_x <= LEFT_LIM) begin
              score2    <= score2_inc;
              serve_dir <= 1'b0;
              ball_hold <= 1'b1;
              frame_cnt <= 8'd0;
              if (score2_inc == WIN_LIM) begin
                winner    <= 2'b10;
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                ball_reset <= 1'b1;
                state      <= SERVE;
              end
            end else if (ball_x >= RIGHT_LIM) begin
              score1    <= score1_inc;
              serve_dir <= 1'b1;
              ball_hold <= 1'b1;
              frame_cnt <= 8'd0;
              if (score1_inc == WIN_LIM) begin
                winner    <= 2'b01;
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                ball_reset <= 1'b1;
                state      <= SERVE;
              end
            end
          end
        end
        OVER: begin
          if (start_edge || (frame_tick && (cnt_inc == OVER_CNT))) begin
            frame_cnt <= 8'd0;
            game_over <= 1'b0;
            menu      <= 1'b1;
            state     <= MENU;
          end else if (frame_tick) begin
            frame_cnt <= cnt_inc;
          end
        end
        default: begin
          state <= MENU;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper: serve timing, goals at both
// borders, win and game-over timeout, async reset and start/tick collision.
module tb_score_keeper;

  logic       clock;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] score1;
  logic [9:0] score2;
  logic       menu;
  logic       game_over;
  logic [1:0] winner;
  logic       ball_hold;
  logic       ball_reset;
  logic       serve_dir;

  int total;
  int passed;

  score_keeper dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .ball_x     (ball_x),
    .score1     (score1),
    .score2     (score2),
    .menu       (menu),
    .game_over  (game_over),
    .winner     (winner),
    .ball_hold  (ball_hold),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One frame tick lasting one clock; returns just after the edge that consumed it.
  task automatic applyStimulus(input int ticks);
    for (int i = 0; i < ticks; i++) begin
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clock);
  endtask

  task automatic pressStart();
    int waited;
    start = 1'b1;
    waited = 0;
    @(negedge clock);
    while (menu === 1'b1 && waited < 4) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("start_leaves_menu", 32'(menu), 32'd0);
    checkOutput("start_ball_reset", 32'(ball_reset), 32'd1);
    checkOutput("start_ball_hold", 32'(ball_hold), 32'd1);
    checkOutput("start_scores", 32'({score1, score2}), 32'd0);
    @(negedge clock);
    checkOutput("start_reset_width", 32'(ball_reset), 32'd0);
    start = 1'b0;
  endtask

  task automatic rightGoalFromServe(input int expScore);
    ball_x = 10'd320;
    applyStimulus(60);
    checkOutput("serve_to_play", 32'(ball_hold), 32'd0);
    ball_x = 10'd630;
    applyStimulus(1);
    checkOutput("right_goal_score1", 32'(score1), 32'(expScore));
    checkOutput("right_goal_dir", 32'(serve_dir), 32'd1);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    frame_tick = 1'b0;
    start = 1'b0;
    ball_x = 10'd320;
    idle(3);
    checkOutput("rst_menu", 32'(menu), 32'd1);
    checkOutput("rst_hold", 32'(ball_hold), 32'd1);
    checkOutput("rst_over", 32'(game_over), 32'd0);
    checkOutput("rst_scores", 32'({score1, score2}), 32'd0);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    checkOutput("rst_ball_reset", 32'(ball_reset), 32'd0);
    reset = 1'b0;
    idle(2);

    applyStimulus(3);
    checkOutput("menu_ignores_tick", 32'(menu), 32'd1);

    pressStart();
    applyStimulus(59);
    checkOutput("serve_hold_59", 32'(ball_hold), 32'd1);
    applyStimulus(1);
    checkOutput("serve_hold_60", 32'(ball_hold), 32'd0);

    ball_x = 10'd11;
    applyStimulus(1);
    ball_x = 10'd629;
    applyStimulus(1);
    checkOutput("near_border_no_goal", 32'({score1, score2}), 32'd0);
    checkOutput("near_border_play", 32'(ball_hold), 32'd0);

    ball_x = 10'd10;
    applyStimulus(1);
    checkOutput("left_goal_score2", 32'(score2), 32'd1);
    checkOutput("left_goal_dir", 32'(serve_dir), 32'd0);
    checkOutput("left_goal_reset", 32'(ball_reset), 32'd1);
    checkOutput("left_goal_hold", 32'(ball_hold), 32'd1);
    idle(1);
    checkOutput("left_goal_reset_width", 32'(ball_reset), 32'd0);

    for (int g = 1; g <= 4; g++) begin
      rightGoalFromServe(g);
      checkOutput("goal_reset_pulse", 32'(ball_reset), 32'd1);
      idle(1);
    end
    rightGoalFromServe(5);
    checkOutput("win_no_reset", 32'(ball_reset), 32'd0);
    checkOutput("win_winner", 32'(winner), 32'd1);
    checkOutput("win_over", 32'(game_over), 32'd1);
    checkOutput("win_score2_kept", 32'(score2), 32'd1);
    idle(1);
    checkOutput("win_no_late_reset", 32'(ball_reset), 32'd0);

    applyStimulus(179);
    checkOutput("over_179", 32'(game_over), 32'd1);
    applyStimulus(1);
    checkOutput("over_to_menu", 32'(menu), 32'd1);
    checkOutput("over_cleared", 32'(game_over), 32'd0);
    checkOutput("menu_keeps_score1", 32'(score1), 32'd5);
    checkOutput("menu_keeps_winner", 32'(winner), 32'd1);

    pressStart();
    checkOutput("new_game_winner", 32'(winner), 32'd0);
    applyStimulus(60);
    ball_x = 10'd5;
    idle(1000);
    checkOutput("no_tick_no_goal", 32'({score1, score2}), 32'd0);
    ball_x = 10'd320;
    applyStimulus(10);
    checkOutput("centre_no_goal", 32'({score1, score2}), 32'd0);
    ball_x = 10'd630;
    applyStimulus(1);
    idle(1);
    rightGoalFromServe(2);
    idle(1);
    rightGoalFromServe(3);
    ball_x = 10'd320;
    applyStimulus(60);
    checkOutput("mid_play_score1", 32'(score1), 32'd3);

    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_score1", 32'(score1), 32'd0);
    checkOutput("async_rst_menu", 32'(menu), 32'd1);
    checkOutput("async_rst_hold", 32'(ball_hold), 32'd1);
    checkOutput("async_rst_dir", 32'(serve_dir), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);

    start = 1'b1;
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    checkOutput("collide_serve", 32'(menu), 32'd0);
    checkOutput("collide_reset", 32'(ball_reset), 32'd1);
    start = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
